// File: rtl/call_stack_pkg.sv
// Shared sizing helpers and operation encoding for the hardware call/return stack.
// Optional build macro CALL_STACK_CIRCULAR_EN is consumed by call_stack_ctx.
package call_stack_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_NUM_CTX = 2;

    // Encoding matches the raw {push, pop} request pair.
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stackOp_e;

    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ctxWidth(input int numCtx);
        return (numCtx > 1) ? $clog2(numCtx) : 1;
    endfunction

    function automatic stackOp_e decodeOp(input logic push, input logic pop);
        return stackOp_e'({push, pop});
    endfunction

endpackage

// File: rtl/call_stack_ctx.sv
// One call-stack context: entry array, stack pointer and sticky error bits.
// With CALL_STACK_CIRCULAR_EN defined, push on full overwrites the oldest entry.
module call_stack_ctx
    import call_stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clrErr,
    input  logic [DATA_W-1:0]       pushData,
    output logic [DATA_W-1:0]       topData,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovf,
    output logic                    udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = countWidth(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     sp;
    logic [CW-1:0]     spNext;
    logic [AW-1:0]     base;
    logic [AW-1:0]     pushIdx;
    logic [AW-1:0]     topIdx;
    logic [AW-1:0]     wrIdx;
    logic              isEmpty;
    logic              isFull;
    logic              doWrite;
    logic              setOvf;
    logic              setUdf;
    stackOp_e          op;
`ifdef CALL_STACK_CIRCULAR_EN
    logic              advBase;
`endif

    assign op      = decodeOp(push, pop);
    assign isEmpty = (sp == '0);
    assign isFull  = (sp == CW'(DEPTH));
    // Indices wrap naturally because DEPTH is a power of two.
    assign pushIdx = base + sp[AW-1:0];
    assign topIdx  = pushIdx - AW'(1);

    always_comb begin
        doWrite = 1'b0;
        wrIdx   = pushIdx;
        spNext  = sp;
        setOvf  = 1'b0;
        setUdf  = 1'b0;
`ifdef CALL_STACK_CIRCULAR_EN
        advBase = 1'b0;
`endif
        case (op)
            OP_PUSH: begin
                if (!isFull) begin
                    doWrite = 1'b1;
                    spNext  = sp + CW'(1);
                end else begin
                    setOvf  = 1'b1;
`ifdef CALL_STACK_CIRCULAR_EN
                    doWrite = 1'b1;
                    advBase = 1'b1;
`endif
                end
            end
            OP_POP: begin
                if (!isEmpty) begin
                    spNext = sp - CW'(1);
                end else begin
                    setUdf = 1'b1;
                end
            end
            OP_REPLACE: begin
                doWrite = 1'b1;
                if (!isEmpty) begin
                    wrIdx = topIdx;
                end else begin
                    // An empty stack cannot be full, so this is a plain push.
                    spNext = sp + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp  <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            sp  <= spNext;
            ovf <= setOvf | (ovf & ~clrErr);
            udf <= setUdf | (udf & ~clrErr);
        end
    end

`ifdef CALL_STACK_CIRCULAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
        end else if (advBase) begin
            base <= base + AW'(1);
        end
    end
`else
    assign base = '0;
`endif

    // Entry storage is deliberately not reset; sp alone defines validity.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrIdx] <= pushData;
        end
    end

    assign topData = isEmpty ? '0 : mem[topIdx];
    assign count   = sp;

endmodule

// File: rtl/call_stack_unit.sv
// Multi-context hardware call/return stack feeding the next-PC mux.
// Build macro CALL_STACK_CIRCULAR_EN selects ring overwrite on full in each context.
module call_stack_unit
    import call_stack_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_CTX = DEF_NUM_CTX
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ctxWidth(NUM_CTX)-1:0]  ctx_sel,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          clr_err,
    output logic [DATA_W-1:0]             top_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = countWidth(DEPTH);

    logic [DATA_W-1:0] ctxTop   [NUM_CTX];
    logic [CW-1:0]     ctxCount [NUM_CTX];
    logic              ctxOvf   [NUM_CTX];
    logic              ctxUdf   [NUM_CTX];

    generate
        for (genvar g = 0; g < NUM_CTX; g++) begin : gCtx
            logic selHit;
            assign selHit = (int'(ctx_sel) == g);

            call_stack_ctx #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) uCtx (
                .clk      (clk),
                .rst_n    (rst_n),
                .push     (push & selHit),
                .pop      (pop & selHit),
                .clrErr   (clr_err & selHit),
                .pushData (push_data),
                .topData  (ctxTop[g]),
                .count    (ctxCount[g]),
                .ovf      (ctxOvf[g]),
                .udf      (ctxUdf[g])
            );
        end
    endgenerate

    // Unused ctx_sel codes (non power-of-two NUM_CTX) read as an empty stack.
    always_comb begin
        top_data  = '0;
        count     = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (int'(ctx_sel) == i) begin
                top_data  = ctxTop[i];
                count     = ctxCount[i];
                overflow  = ctxOvf[i];
                underflow = ctxUdf[i];
            end
        end
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
    end

endmodule

// File: tb/tb_call_stack_unit.sv
// Bench for call_stack_unit: array-based LIFO model checked every cycle plus literal checkpoints.
module tb_call_stack_unit;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int NUM_CTX = 2;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [0:0]        ctx_sel = '0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic [DATA_W-1:0] push_data = '0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] top_data;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mData [NUM_CTX][DEPTH];
    int                mCnt  [NUM_CTX];
    bit                mOvf  [NUM_CTX];
    bit                mUdf  [NUM_CTX];

    call_stack_unit #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .NUM_CTX (NUM_CTX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctx_sel   (ctx_sel),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clr_err   (clr_err),
        .top_data  (top_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each context is an array used as a plain LIFO list, index 0 = oldest.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                mCnt[c] = 0;
                mOvf[c] = 1'b0;
                mUdf[c] = 1'b0;
            end
        end else begin
            int c;
            bit eo;
            bit eu;
            c  = int'(ctx_sel);
            eo = 1'b0;
            eu = 1'b0;
            if (push) begin
                if (pop && mCnt[c] > 0) begin
                    mData[c][mCnt[c]-1] = push_data;
                end else if (mCnt[c] < DEPTH) begin
                    mData[c][mCnt[c]] = push_data;
                    mCnt[c]++;
                end else begin
                    eo = 1'b1;
`ifdef CALL_STACK_CIRCULAR_EN
                    for (int i = 0; i < DEPTH - 1; i++) mData[c][i] = mData[c][i+1];
                    mData[c][DEPTH-1] = push_data;
`endif
                end
            end else if (pop) begin
                if (mCnt[c] > 0) mCnt[c]--;
                else eu = 1'b1;
            end
            if (clr_err) begin
                mOvf[c] = 1'b0;
                mUdf[c] = 1'b0;
            end
            if (eo) mOvf[c] = 1'b1;
            if (eu) mUdf[c] = 1'b1;
        end
    end

    always @(negedge clk) begin
        int c;
        logic [31:0] expTop;
        c = int'(ctx_sel);
        expTop = '0;
        if (mCnt[c] > 0) expTop = mData[c][mCnt[c]-1];
        chk("cyc top_data", top_data, expTop);
        chk("cyc count", 32'(count), 32'(mCnt[c]));
        chk("cyc empty", 32'(empty), 32'(mCnt[c] == 0));
        chk("cyc full", 32'(full), 32'(mCnt[c] == DEPTH));
        chk("cyc overflow", 32'(overflow), 32'(mOvf[c]));
        chk("cyc underflow", 32'(underflow), 32'(mUdf[c]));
    end

    task automatic op(input int c, input bit pu, input bit po, input logic [31:0] d, input bit clr);
        ctx_sel   = 1'(c);
        push      = pu;
        pop       = po;
        push_data = d;
        clr_err   = clr;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset underflow", 32'(underflow), 32'd0);
        chk("reset top", top_data, 32'h0);

        op(0, 1, 0, 32'h10, 0);
        op(0, 1, 0, 32'h20, 0);
        op(0, 1, 0, 32'h30, 0);
        chk("basic count3", 32'(count), 32'd3);
        chk("basic top30", top_data, 32'h30);
        op(0, 0, 1, 0, 0);
        op(0, 0, 1, 0, 0);
        chk("basic top10", top_data, 32'h10);
        chk("basic count1", 32'(count), 32'd1);

        doReset();
        for (int v = 1; v <= 4; v++) op(0, 1, 0, 32'(v), 0);
        chk("full after 4", 32'(full), 32'd1);
        chk("no ovf yet", 32'(overflow), 32'd0);
        op(0, 1, 0, 32'd5, 0);
        chk("full count", 32'(count), 32'd4);
        chk("full ovf", 32'(overflow), 32'd1);
`ifdef CALL_STACK_CIRCULAR_EN
        chk("circ top5", top_data, 32'd5);
        for (int v = 5; v >= 2; v--) begin
            chk("circ pop value", top_data, 32'(v));
            op(0, 0, 1, 0, 0);
        end
`else
        chk("sat top4", top_data, 32'd4);
        for (int v = 4; v >= 1; v--) begin
            chk("sat pop value", top_data, 32'(v));
            op(0, 0, 1, 0, 0);
        end
`endif
        chk("drained empty", 32'(empty), 32'd1);
        chk("ovf sticky", 32'(overflow), 32'd1);

        op(1, 0, 1, 0, 0);
        chk("udf set", 32'(underflow), 32'd1);
        chk("udf count0", 32'(count), 32'd0);
        op(1, 0, 1, 0, 1);
        chk("udf set beats clr", 32'(underflow), 32'd1);
        op(1, 0, 0, 0, 1);
        chk("udf cleared", 32'(underflow), 32'd0);
        ctx_sel = 1'b0;
        #1;
        chk("ctx0 ovf untouched", 32'(overflow), 32'd1);
        op(0, 0, 0, 0, 1);
        chk("ovf cleared", 32'(overflow), 32'd0);

        op(1, 1, 0, 32'hA, 0);
        op(1, 1, 0, 32'hB, 0);
        op(1, 1, 1, 32'hC, 0);
        chk("replace count", 32'(count), 32'd2);
        chk("replace top", top_data, 32'hC);
        op(1, 0, 1, 0, 0);
        chk("replace pop top", top_data, 32'hA);

        doReset();
        op(1, 1, 1, 32'h77, 0);
        chk("replace empty count", 32'(count), 32'd1);
        chk("replace empty top", top_data, 32'h77);
        chk("replace empty no udf", 32'(underflow), 32'd0);

        doReset();
        op(0, 1, 0, 32'h111, 0);
        op(1, 1, 0, 32'h222, 0);
        ctx_sel = 1'b0;
        #1;
        chk("iso top ctx0", top_data, 32'h111);
        ctx_sel = 1'b1;
        #1;
        chk("iso top ctx1", top_data, 32'h222);
        op(1, 0, 1, 0, 0);
        op(1, 0, 1, 0, 0);
        chk("iso ctx1 udf", 32'(underflow), 32'd1);
        ctx_sel = 1'b0;
        #1;
        chk("iso ctx0 count", 32'(count), 32'd1);

        op(0, 1, 0, 32'h333, 0);
        chk("pre-reset count2", 32'(count), 32'd2);
        ctx_sel   = 1'b0;
        push      = 1'b1;
        push_data = 32'h99;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async empty", 32'(empty), 32'd1);
        chk("async count", 32'(count), 32'd0);
        chk("async top", top_data, 32'h0);
        ctx_sel = 1'b1;
        #1;
        chk("async udf ctx1", 32'(underflow), 32'd0);
        ctx_sel = 1'b0;
        @(posedge clk);
        #1;
        push  = 1'b0;
        rst_n = 1'b1;
        op(0, 0, 0, 0, 0);
        chk("push discarded", 32'(count), 32'd0);
        chk("push discarded empty", 32'(empty), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                op(int'($urandom_range(0, 1)),
                   $urandom_range(0, 99) < 45,
                   $urandom_range(0, 99) < 40,
                   $urandom,
                   $urandom_range(0, 99) < 8);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
